nrs_re_mapper: RTL and testbench
================================

Name: nrs_re_mapper

Overview:
Downstream consumer of the Tx NRS value generator. Once per NRS-bearing subframe, it reads the 16-word pilot register file (4 OFDM symbols × 2 pilots × real/imag) through the generator's four read-address ports. It computes each pilot's subcarrier from N_cell_ID for antenna port 2000 and streams the 8 complex pilots into the subframe resource-grid buffer over a valid/ready write interface.

Parameters:
WIDTH_REG, 16, width of one real or imaginary pilot word (Q-format as produced by the generator).
LINES, 4, read-address width (clog2 of WIDTH_REG entries).
WIDTH_B, 9, N_cell_ID width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
nrs_ready  in  1  one-cycle pulse: generator has all 16 words for the current subframe
nrs_blank  in  1  sampled with nrs_ready; high = subframe carries no NRS (NPSS/NSSS)
N_cell_ID  in  WIDTH_B  physical cell ID 0..503, sampled with nrs_ready
rd_addr_mapper_1r, rd_addr_mapper_1i, rd_addr_mapper_2r, rd_addr_mapper_2i  out  LINES each  generator read addresses
nrs_mapper_1r, nrs_mapper_1i, nrs_mapper_2r, nrs_mapper_2i  in  WIDTH_REG each  read data, valid one cycle after the address
re_wr_valid  out  1  grid write request
re_wr_ready  in  1  grid buffer accepts the write
re_wr_sym  out  4  OFDM symbol in subframe, 0..13
re_wr_sc  out  4  subcarrier, 0..11
re_wr_data_r, re_wr_data_i  out  WIDTH_REG each  pilot value
busy  out  1  high from accepted nrs_ready until done
done  out  1  one-cycle pulse when the subframe's mapping is complete
start_err  out  1  one-cycle pulse: nrs_ready received while busy

Behaviour:
- Reset: all outputs are 0; FSM is in IDLE; holding registers are cleared.
- FSM states: IDLE, RD_ADDR, RD_CAP, WR_P1, WR_P2, FIN.
- IDLE:
  - On nrs_ready, latch v_shift = N_cell_ID mod 6, clear the symbol counter s (2 bits) and set busy.
  - If nrs_blank=1, go to FIN; otherwise go to RD_ADDR.
- RD_ADDR: drive 1r=4s, 1i=4s+1, 2r=4s+2, 2i=4s+3, then go to RD_CAP.
- RD_CAP: capture all four read words into holding registers, then go to WR_P1.
- WR_P1:
  - re_wr_valid=1; re_wr_sym=SYM(s); re_wr_sc=k0; data = captured 1r/1i.
  - Hold all outputs stable until re_wr_ready=1, then go to WR_P2.
- WR_P2:
  - Same as WR_P1 with re_wr_sc=k0+6 and data = captured 2r/2i.
  - On ready: if s==3 go to FIN; otherwise increment s and go to RD_ADDR.
- FIN: pulse done for one cycle, clear busy, go to IDLE.
- SYM(s) = {5, 6, 12, 13} for s = 0..3.
- k0 = (v + v_shift) mod 6, with v=0 for even s (l=5) and v=3 for odd s (l=6). k0 is always 0..5, so k0+6 ≤ 11.
- mod 6 of the 9-bit ID is computed combinationally and registered at start. Valid range is 0..503; values 504..511 are still reduced mod 6 with no error.
- Latency with re_wr_ready tied high:
  - nrs_ready sampled at edge N; addresses are driven during cycle N+1.
  - First write is valid in cycle N+3; each symbol takes 4 cycles.
  - Last write accepted at N+16; done high in cycle N+17.
  - Blank subframe: done in cycle N+2.
- re_wr_ready low never drops or reorders data; back-pressure only stretches WR_P1/WR_P2.
- nrs_ready while busy is ignored (the current subframe continues) and pulses start_err the next cycle. nrs_ready on the same cycle as done, or later, is accepted.
- Read addresses hold their last value outside RD_ADDR; the generator is read-only from this block.
- rst mid-operation: next cycle is IDLE with re_wr_valid=0 and busy=0; no done pulse.

Decomposition:
- Shared package nrs_pkg holds:
  - NRS_SYM table {5,6,12,13};
  - SC_PER_RB=12 and PILOT_SPACING=6;
  - v offsets V_L5=0 and V_L6=3;
  - the FSM state enum;
  - WIDTH_REG/LINES defaults.
- One sub-module, cell_id_mod6 (9-bit mod-6 reducer), shared with the Rx channel estimator.

Test Plan:
- N_cell_ID=0, generator words alternating 0x0B58/0xF4A8, ready tied 1 -> 8 writes (sym,sc) = (5,0),(5,6),(6,3),(6,9),(12,0),(12,6),(13,3),(13,9); data matches words 0..15 in order; done at N+17.
- N_cell_ID=7 -> subcarriers 1,7 / 4,10 per symbol pair; N_cell_ID=503 -> 5,11 / 2,8.
- Random re_wr_ready stalls (≈50%) -> outputs stable while stalled, same 8 writes in order, no duplicates.
- nrs_blank=1 with nrs_ready -> zero writes, done in cycle N+2.
- Second nrs_ready during the 3rd write -> start_err pulse, mapping completes unchanged, exactly one done.
- rst asserted during WR_P1 of s=2 -> re_wr_valid=0 and busy=0 next cycle; a fresh nrs_ready then produces a full, correct 8-write sequence.

Source files
------------

// File: rtl/nrs_pkg.sv
// Shared constants and types for the NRS resource-element mapper and its helpers.
// Contents: pilot symbol table, subcarrier spacing constants, v offsets, FSM state enum,
// default word/address widths, and small helpers for the symbol and k0 lookups.
package nrs_pkg;

  localparam int unsigned NRS_WIDTH_REG = 16;
  localparam int unsigned NRS_LINES     = 4;
  localparam int unsigned NRS_WIDTH_B   = 9;

  localparam int unsigned SC_PER_RB     = 12;
  localparam int unsigned PILOT_SPACING = 6;

  // v offset for the first (l=5) and second (l=6) NRS symbol of each slot.
  localparam int unsigned V_L5 = 0;
  localparam int unsigned V_L6 = 3;

  // OFDM symbol index of the s-th NRS-bearing symbol in the subframe.
  localparam logic [3:0] NRS_SYM [4] = '{4'd5, 4'd6, 4'd12, 4'd13};

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdCap,
    StWrP1,
    StWrP2,
    StFin
  } nrs_state_e;

  function automatic logic [3:0] nrs_sym(input logic [1:0] s);
    return NRS_SYM[s];
  endfunction

  // First pilot subcarrier: (v + v_shift) mod 6, v selected by symbol parity.
  function automatic logic [3:0] nrs_k0(input logic [2:0] vshift, input logic odd);
    logic [3:0] sum;
    sum = {1'b0, vshift} + (odd ? 4'(V_L6) : 4'(V_L5));
    if (sum >= 4'(PILOT_SPACING)) begin
      sum = sum - 4'(PILOT_SPACING);
    end
    return sum;
  endfunction

endpackage

// File: rtl/cell_id_mod6.sv
// Combinational 9-bit mod-6 reducer for the physical cell ID.
// Ports: id_i  - 9-bit cell ID (0..511, values above 503 reduce normally)
//        mod6_o - id_i mod 6 (0..5)
// mod 3 is taken from the sum of base-4 digits (4 = 1 mod 3); mod 2 is bit 0; the two
// residues are then combined by a small CRT table.
module cell_id_mod6 (
  input  logic [8:0] id_i,
  output logic [2:0] mod6_o
);

  logic [3:0] dsum;
  logic [2:0] d2;
  logic [1:0] r3;

  assign dsum = 4'(id_i[1:0]) + 4'(id_i[3:2]) + 4'(id_i[5:4]) + 4'(id_i[7:6]) + 4'(id_i[8]);
  assign d2   = 3'(dsum[3:2]) + 3'(dsum[1:0]);

  always_comb begin
    if (d2 >= 3'd6) begin
      r3 = 2'd0;
    end else if (d2 >= 3'd3) begin
      r3 = 2'(d2 - 3'd3);
    end else begin
      r3 = d2[1:0];
    end
  end

  always_comb begin
    mod6_o = 3'd0;
    unique case ({r3, id_i[0]})
      3'b000:  mod6_o = 3'd0;
      3'b001:  mod6_o = 3'd3;
      3'b010:  mod6_o = 3'd4;
      3'b011:  mod6_o = 3'd1;
      3'b100:  mod6_o = 3'd2;
      3'b101:  mod6_o = 3'd5;
      default: mod6_o = 3'd0;
    endcase
  end

endmodule

// File: rtl/nrs_re_mapper.sv
// NRS resource-element mapper for antenna port 2000.
// Reads the generator's 16-word pilot file (4 symbols x 2 pilots x re/im) one symbol at a
// time and streams the 8 complex pilots to the resource-grid buffer via valid/ready.
// Ports: clk/rst (sync, active high); nrs_ready/nrs_blank/N_cell_ID start a subframe;
//        rd_addr_mapper_* / nrs_mapper_* generator read ports (data one cycle after addr);
//        re_wr_* grid write interface; busy/done/start_err status.
module nrs_re_mapper
  import nrs_pkg::*;
#(
  parameter int unsigned WIDTH_REG = NRS_WIDTH_REG,
  parameter int unsigned LINES     = NRS_LINES,
  parameter int unsigned WIDTH_B   = NRS_WIDTH_B
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 nrs_ready,
  input  logic                 nrs_blank,
  input  logic [WIDTH_B-1:0]   N_cell_ID,
  output logic [LINES-1:0]     rd_addr_mapper_1r,
  output logic [LINES-1:0]     rd_addr_mapper_1i,
  output logic [LINES-1:0]     rd_addr_mapper_2r,
  output logic [LINES-1:0]     rd_addr_mapper_2i,
  input  logic [WIDTH_REG-1:0] nrs_mapper_1r,
  input  logic [WIDTH_REG-1:0] nrs_mapper_1i,
  input  logic [WIDTH_REG-1:0] nrs_mapper_2r,
  input  logic [WIDTH_REG-1:0] nrs_mapper_2i,
  output logic                 re_wr_valid,
  input  logic                 re_wr_ready,
  output logic [3:0]           re_wr_sym,
  output logic [3:0]           re_wr_sc,
  output logic [WIDTH_REG-1:0] re_wr_data_r,
  output logic [WIDTH_REG-1:0] re_wr_data_i,
  output logic                 busy,
  output logic                 done,
  output logic                 start_err
);

  nrs_state_e state_q, state_d;
  logic [1:0] s_q, s_d;
  logic [2:0] vshift_q, vshift_d, vshift_comb;
  // Set on a blank start: FIN then spends one extra cycle before pulsing done.
  logic       blank_q, blank_d;
  logic       start_err_q, start_err_d;
  logic [LINES-1:0] a1r_q, a1i_q, a2r_q, a2i_q;
  logic [LINES-1:0] a1r_d, a1i_d, a2r_d, a2i_d;
  logic [WIDTH_REG-1:0] c1r_q, c1i_q, c2r_q, c2i_q;
  logic [WIDTH_REG-1:0] c1r_d, c1i_d, c2r_d, c2i_d;

  logic [LINES-1:0] addr_base;
  logic [3:0]       k0;
  logic             fin_done;
  logic             start_ok;

  cell_id_mod6 u_mod6 (
    .id_i  (9'(N_cell_ID)),
    .mod6_o(vshift_comb)
  );

  assign addr_base = LINES'({s_q, 2'b00});
  assign k0        = nrs_k0(vshift_q, s_q[0]);
  assign fin_done  = (state_q == StFin) && !blank_q;
  // The done cycle doubles as an accept slot so subframes can run back to back.
  assign start_ok  = nrs_ready && ((state_q == StIdle) || fin_done);
  assign busy      = (state_q != StIdle) && !fin_done;
  assign start_err_d = nrs_ready && busy;
  assign start_err   = start_err_q;

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    vshift_d = vshift_q;
    blank_d  = blank_q;
    a1r_d    = a1r_q;
    a1i_d    = a1i_q;
    a2r_d    = a2r_q;
    a2i_d    = a2i_q;
    c1r_d    = c1r_q;
    c1i_d    = c1i_q;
    c2r_d    = c2r_q;
    c2i_d    = c2i_q;
    re_wr_valid  = 1'b0;
    re_wr_sym    = 4'd0;
    re_wr_sc     = 4'd0;
    re_wr_data_r = '0;
    re_wr_data_i = '0;
    done         = 1'b0;

    unique case (state_q)
      StIdle: begin
      end
      StRdAddr: begin
        a1r_d   = addr_base;
        a1i_d   = addr_base + LINES'(1);
        a2r_d   = addr_base + LINES'(2);
        a2i_d   = addr_base + LINES'(3);
        state_d = StRdCap;
      end
      StRdCap: begin
        c1r_d   = nrs_mapper_1r;
        c1i_d   = nrs_mapper_1i;
        c2r_d   = nrs_mapper_2r;
        c2i_d   = nrs_mapper_2i;
        state_d = StWrP1;
      end
      StWrP1: begin
        re_wr_valid  = 1'b1;
        re_wr_sym    = nrs_sym(s_q);
        re_wr_sc     = k0;
        re_wr_data_r = c1r_q;
        re_wr_data_i = c1i_q;
        if (re_wr_ready) begin
          state_d = StWrP2;
        end
      end
      StWrP2: begin
        re_wr_valid  = 1'b1;
        re_wr_sym    = nrs_sym(s_q);
        re_wr_sc     = k0 + 4'(PILOT_SPACING);
        re_wr_data_r = c2r_q;
        re_wr_data_i = c2i_q;
        if (re_wr_ready) begin
          if (s_q == 2'd3) begin
            state_d = StFin;
          end else begin
            s_d     = s_q + 2'd1;
            state_d = StRdAddr;
          end
        end
      end
      StFin: begin
        if (blank_q) begin
          blank_d = 1'b0;
        end else begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_ok) begin
      vshift_d = vshift_comb;
      s_d      = 2'd0;
      blank_d  = nrs_blank;
      state_d  = nrs_blank ? StFin : StRdAddr;
    end
  end

  // Addresses are live during RD_ADDR and hold their last value otherwise.
  assign rd_addr_mapper_1r = a1r_d;
  assign rd_addr_mapper_1i = a1i_d;
  assign rd_addr_mapper_2r = a2r_d;
  assign rd_addr_mapper_2i = a2i_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      s_q         <= 2'd0;
      vshift_q    <= 3'd0;
      blank_q     <= 1'b0;
      start_err_q <= 1'b0;
      a1r_q       <= '0;
      a1i_q       <= '0;
      a2r_q       <= '0;
      a2i_q       <= '0;
      c1r_q       <= '0;
      c1i_q       <= '0;
      c2r_q       <= '0;
      c2i_q       <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      vshift_q    <= vshift_d;
      blank_q     <= blank_d;
      start_err_q <= start_err_d;
      a1r_q       <= a1r_d;
      a1i_q       <= a1i_d;
      a2r_q       <= a2r_d;
      a2i_q       <= a2i_d;
      c1r_q       <= c1r_d;
      c1i_q       <= c1i_d;
      c2r_q       <= c2r_d;
      c2i_q       <= c2i_d;
    end
  end

endmodule

// File: tb/tb_nrs_re_mapper.sv
// Self-checking bench for nrs_re_mapper: generator read-port model, randomized stalls,
// a per-cycle scoreboard derived from the pilot mapping rules, and literal pins.
module tb_nrs_re_mapper;

  localparam int unsigned WR = 16;
  localparam int unsigned LN = 4;
  localparam int unsigned WB = 9;

  typedef struct {
    logic [3:0]  sym;
    logic [3:0]  sc;
    logic [15:0] dr;
    logic [15:0] di;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          nrs_ready = 1'b0;
  logic          nrs_blank = 1'b0;
  logic [WB-1:0] N_cell_ID = '0;
  logic [LN-1:0] ra1r, ra1i, ra2r, ra2i;
  logic [WR-1:0] d1r, d1i, d2r, d2i;
  logic          re_wr_valid;
  logic          re_wr_ready = 1'b1;
  logic [3:0]    re_wr_sym, re_wr_sc;
  logic [WR-1:0] re_wr_data_r, re_wr_data_i;
  logic          busy, done, start_err;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   rdy_rand = 1'b0;
  logic [15:0] mem [16];
  wr_t  exp_q [$];

  nrs_re_mapper #(.WIDTH_REG(WR), .LINES(LN), .WIDTH_B(WB)) dut (
    .clk              (clk),
    .rst              (rst),
    .nrs_ready        (nrs_ready),
    .nrs_blank        (nrs_blank),
    .N_cell_ID        (N_cell_ID),
    .rd_addr_mapper_1r(ra1r),
    .rd_addr_mapper_1i(ra1i),
    .rd_addr_mapper_2r(ra2r),
    .rd_addr_mapper_2i(ra2i),
    .nrs_mapper_1r    (d1r),
    .nrs_mapper_1i    (d1i),
    .nrs_mapper_2r    (d2r),
    .nrs_mapper_2i    (d2i),
    .re_wr_valid      (re_wr_valid),
    .re_wr_ready      (re_wr_ready),
    .re_wr_sym        (re_wr_sym),
    .re_wr_sc         (re_wr_sc),
    .re_wr_data_r     (re_wr_data_r),
    .re_wr_data_i     (re_wr_data_i),
    .busy             (busy),
    .done             (done),
    .start_err        (start_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Generator register file: read data appears one cycle after the address.
  always @(posedge clk) begin
    d1r <= mem[ra1r];
    d1i <= mem[ra1i];
    d2r <= mem[ra2r];
    d2i <= mem[ra2i];
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      re_wr_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: per-cycle checks against a model of accepted subframes.
  initial begin
    int  syms [4] = '{5, 6, 12, 13};
    wr_t w, prev_w;
    bit  prev_stall = 1'b0;
    bit  busy_m = 1'b0;
    bit  err_m = 1'b0;
    bit  idle_now;
    int  done_cyc = -10;
    int  c, vs, k0;
    forever begin
      @(negedge clk);
      c = cyc;
      if (c >= 3) begin
        chk("done", done, c == done_cyc);
        chk("busy", busy, busy_m && (c != done_cyc));
        chk("start_err", start_err, err_m);
        if (prev_stall) begin
          chk("stall_valid", re_wr_valid, 1);
          chk("stall_hold", {re_wr_sym, re_wr_sc, re_wr_data_r, re_wr_data_i},
              {prev_w.sym, prev_w.sc, prev_w.dr, prev_w.di});
        end
        if (re_wr_valid) begin
          chk("wr_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            w = exp_q[0];
            chk("wr_sym", re_wr_sym, w.sym);
            chk("wr_sc", re_wr_sc, w.sc);
            chk("wr_data_r", re_wr_data_r, w.dr);
            chk("wr_data_i", re_wr_data_i, w.di);
            if (re_wr_ready) begin
              void'(exp_q.pop_front());
              if (exp_q.size() == 0) done_cyc = c + 1;
            end
          end
        end
        prev_stall = re_wr_valid && !re_wr_ready;
        prev_w.sym = re_wr_sym;
        prev_w.sc  = re_wr_sc;
        prev_w.dr  = re_wr_data_r;
        prev_w.di  = re_wr_data_i;
      end
      if (rst) begin
        exp_q.delete();
        busy_m     = 1'b0;
        err_m      = 1'b0;
        done_cyc   = -10;
        prev_stall = 1'b0;
      end else begin
        idle_now = !busy_m || (c == done_cyc);
        err_m    = nrs_ready && !idle_now;
        if (nrs_ready && idle_now) begin
          busy_m = 1'b1;
          if (nrs_blank) begin
            done_cyc = c + 2;
          end else begin
            vs = int'(N_cell_ID) % 6;
            for (int s = 0; s < 4; s++) begin
              k0 = ((s % 2) * 3 + vs) % 6;
              for (int p = 0; p < 2; p++) begin
                w.sym = 4'(syms[s]);
                w.sc  = 4'(k0 + 6 * p);
                w.dr  = mem[4 * s + 2 * p];
                w.di  = mem[4 * s + 2 * p + 1];
                exp_q.push_back(w);
              end
            end
          end
        end else if (c == done_cyc) begin
          busy_m = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int id, input bit blank, output int n);
    N_cell_ID = WB'(id);
    nrs_blank = blank;
    nrs_ready = 1'b1;
    tick();
    n = cyc;
    nrs_ready = 1'b0;
    nrs_blank = 1'b0;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 400) begin
      tick();
      k++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 400) begin
      tick();
      k++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem[i] = (i % 2 == 1) ? 16'hF4A8 : 16'h0B58;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    // Reset state
    chk("rst_valid", re_wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", {ra1r, ra1i, ra2r, ra2i}, 0);
    chk("rst_data", {re_wr_sym, re_wr_sc, re_wr_data_r, re_wr_data_i}, 0);

    // Cell 0, ready tied high: literal timing and placement
    start(0, 1'b0, n);
    chk("t1_addr_1r", ra1r, 0);
    chk("t1_addr_2i", ra2i, 3);
    wait_to(n + 2);
    chk("t1_w0_valid", re_wr_valid, 1);
    chk("t1_w0", {re_wr_sym, re_wr_sc, re_wr_data_r, re_wr_data_i}, 40'h50_0B58_F4A8);
    tick();
    chk("t1_w1_sc", re_wr_sc, 6);
    wait_to(n + 6);
    chk("t1_w2", {re_wr_sym, re_wr_sc}, 8'h63);
    wait_to(n + 15);
    chk("t1_w7", {re_wr_sym, re_wr_sc}, 8'hD9);
    chk("t1_no_early_done", done, 0);
    tick();
    chk("t1_done_n17", done, 1);
    tick();
    chk("t1_addr_hold", {ra1r, ra1i, ra2r, ra2i}, 16'hCDEF);

    // Cell 7 and cell 503 subcarrier pins
    fill_random();
    start(7, 1'b0, n);
    wait_to(n + 2);
    chk("c7_sc0", re_wr_sc, 1);
    wait_to(n + 7);
    chk("c7_sc3", re_wr_sc, 10);
    wait_idle();
    fill_random();
    start(503, 1'b0, n);
    wait_to(n + 3);
    chk("c503_sc1", re_wr_sc, 11);
    wait_to(n + 6);
    chk("c503_sc2", re_wr_sc, 2);
    wait_idle();
    start(510, 1'b0, n);
    wait_idle();

    // Blank subframe
    start(100, 1'b1, n);
    chk("blank_busy", busy, 1);
    tick();
    chk("blank_done_n2", done, 1);
    chk("blank_novalid", re_wr_valid, 0);
    tick();

    // Second nrs_ready during the third write
    fill_random();
    start(37, 1'b0, n);
    wait_to(n + 6);
    nrs_ready = 1'b1;
    N_cell_ID = 9'd1;
    tick();
    nrs_ready = 1'b0;
    chk("err_pulse", start_err, 1);
    wait_to(n + 16);
    chk("err_done", done, 1);
    tick();
    chk("err_after_busy", busy, 0);

    // Reset during WR_P1 of s=2
    fill_random();
    start(250, 1'b0, n);
    wait_to(n + 10);
    chk("rst_mid_sym", {re_wr_valid, re_wr_sym}, 5'h1C);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", re_wr_valid, 0);
    chk("rst_mid_busy", busy, 0);
    tick();
    fill_random();
    start(250, 1'b0, n);
    wait_to(n + 2);
    chk("rst_fresh_w0", {re_wr_valid, re_wr_sym, re_wr_sc}, 9'h154);
    wait_idle();

    // Random back-pressure, back-to-back and blank jobs
    rdy_rand = 1'b1;
    for (int j = 0; j < 8; j++) begin
      fill_random();
      start(int'($urandom_range(0, 511)), (j == 3), n);
      wait_done();
      if (j % 2 == 0) tick();
    end
    wait_idle();
    rdy_rand = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
